// File: rtl/gal_olmc_bank.sv
// Bank of GAL output logic macrocells with a streamed, atomically committed mode config.
// Optional synchronous preset input SP is enabled by defining GAL_OLMC_SP_EN.
module gal_olmc_bank #(
  parameter int N = 8
) (
  input  logic         C,
  input  logic         AR_N,
  input  logic [N-1:0] A,
  input  logic [N-1:0] OE,
  output logic [N-1:0] Y,
  output logic [N-1:0] Y_EN,
  output logic [N-1:0] FB,
`ifdef GAL_OLMC_SP_EN
  input  logic         SP,
`endif
  input  logic         cfg_valid,
  input  logic [1:0]   cfg_data,
  output logic         cfg_ready,
  output logic         cfg_busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t        state;
  logic [CW-1:0] idx;
  logic [N-1:0]  q;
  logic [N-1:0]  sh_reg, sh_inv;
  logic [N-1:0]  act_reg, act_inv;
  logic [N-1:0]  sel;

  always_ff @(posedge C or negedge AR_N) begin
    if (!AR_N) begin
      q <= '0;
    end else begin
`ifdef GAL_OLMC_SP_EN
      q <= SP ? '1 : A;
`else
      q <= A;
`endif
    end
  end

  // Beats land in the shadow; the active mode only changes on the COMMIT edge.
  always_ff @(posedge C or negedge AR_N) begin
    if (!AR_N) begin
      state     <= IDLE;
      idx       <= '0;
      sh_reg    <= '0;
      sh_inv    <= '0;
      act_reg   <= '0;
      act_inv   <= '0;
      cfg_ready <= 1'b1;
      cfg_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            sh_reg[0] <= cfg_data[1];
            sh_inv[0] <= cfg_data[0];
            cfg_busy  <= 1'b1;
            if (N == 1) begin
              state     <= COMMIT;
              idx       <= '0;
              cfg_ready <= 1'b0;
            end else begin
              state <= LOAD;
              idx   <= CW'(1);
            end
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            sh_reg[idx] <= cfg_data[1];
            sh_inv[idx] <= cfg_data[0];
            if (idx == LAST_IDX) begin
              state     <= COMMIT;
              cfg_ready <= 1'b0;
            end else begin
              idx <= idx + CW'(1);
            end
          end
        end
        COMMIT: begin
          act_reg   <= sh_reg;
          act_inv   <= sh_inv;
          idx       <= '0;
          state     <= IDLE;
          cfg_ready <= 1'b1;
          cfg_busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          cfg_ready <= 1'b1;
          cfg_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sel  = (act_reg & q) | (~act_reg & A);
    Y    = sel ^ act_inv;
    FB   = (act_reg & q) | (~act_reg & Y);
    Y_EN = OE;
  end

endmodule
